// File: rtl/instr_decode_if.sv
// instr_decode_if: bundles the instruction-stream handshake, the flush
// control and the decoded-bundle outputs of instr_decode_stage.
//
// Handshake semantics (both sides): a transfer happens at a rising clock
// edge where valid && ready are both high. A source holding valid high keeps
// its payload stable until that edge; ready never depends combinationally
// on valid.
//
// Signals:
//   in_valid/in_ready/in_instr  upstream word stream (25-bit instruction)
//   flush                       synchronous clear of FIFO and output stage
//   out_valid/out_ready         downstream decoded-bundle handshake
//   out_fmt..out_use            decoded fields
//   instr_count                 bundles delivered downstream (saturating)
//
// Modports: slave = decode stage view, master = driver/consumer view.
interface instr_decode_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_fmt;
    logic [7:0]       out_op;
    logic [15:0]      out_imm;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rs3;
    logic [2:0]       out_use;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_fmt, out_op, out_imm,
               out_rd, out_rs1, out_rs2, out_rs3, out_use, instr_count
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_fmt, out_op, out_imm,
               out_rd, out_rs1, out_rs2, out_rs3, out_use, instr_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: consumer end of the SIMD instruction stream.
// Words accepted from the instruction buffer are queued in a DEPTH-entry
// FIFO; the head is decoded and registered into a field bundle for the
// register-file/ALU stage. A word accepted at edge N is presented after
// edge N+1 (no bypass); one word per clock is sustained with out_ready high.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instr_decode_if.slave (stream in, flush, bundle out, count)
//
// Formats: [24]=0 -> LI (fmt 0), [24:23]=10 -> R4 (fmt 1),
//          [24:23]=11 -> R3 (fmt 2).
module instr_decode_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    instr_decode_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]  fmt;
        logic [7:0]  op;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [2:0]  rd_en;
    } bundle_t;

    logic [24:0]      mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             load;
    logic [24:0]      head;
    bundle_t          dec;
    bundle_t          out_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] count_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the indices match.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // in_ready comes only from registered pointers: a pop in the same cycle
    // does not open a slot for a push until the following cycle.
    assign push = bus.in_valid && !full && !bus.flush;
    assign load = (!out_valid_q || bus.out_ready) && !empty && !bus.flush;

    always_comb begin
        dec = '0;
        if (!head[24]) begin
            // LI: rd is both destination and the single read source.
            dec.fmt   = 2'd0;
            dec.op    = {5'b0, head[23:21]};
            dec.imm   = head[20:5];
            dec.rd    = head[4:0];
            dec.rs1   = head[4:0];
            dec.rd_en = 3'b001;
        end else if (!head[23]) begin
            dec.fmt   = 2'd1;
            dec.op    = {5'b0, head[22:20]};
            dec.rd    = head[4:0];
            dec.rs1   = head[9:5];
            dec.rs2   = head[14:10];
            dec.rs3   = head[19:15];
            dec.rd_en = 3'b111;
        end else begin
            dec.fmt   = 2'd2;
            dec.op    = head[22:15];
            dec.rd    = head[4:0];
            dec.rs1   = head[9:5];
            dec.rs2   = head[14:10];
            dec.rd_en = 3'b011;
        end
    end

    // Storage array needs no reset; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Output stage: fields hold their last value when the stage drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Delivered count survives flush and saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (out_valid_q && bus.out_ready && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.in_ready    = !full;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_op      = out_q.op;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_rs3     = out_q.rs3;
    assign bus.out_use     = out_q.rd_en;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed decode vectors, stall/backpressure,
// flush, asynchronous reset and a random stream checked against a
// scoreboard queue of expected bundles.
module tb_instr_decode_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_decode_if #(.CNT_W(CNT_W)) bus ();

    instr_decode_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [48:0] exp_q[$];
    logic [CNT_W-1:0] exp_count;

    // Reference decode: {fmt, op, imm, rd, rs1, rs2, rs3, use}
    function automatic logic [48:0] model(input logic [24:0] w);
        logic [1:0] f;
        logic [7:0] o;
        logic [15:0] im;
        logic [4:0] r1, r2, r3;
        logic [2:0] u;
        im = 16'h0; r2 = 5'd0; r3 = 5'd0;
        case (w[24:23])
            2'b10: begin f = 2'd1; o = 8'(w[22:20]); r1 = w[9:5]; r2 = w[14:10];
                         r3 = w[19:15]; u = 3'b111; end
            2'b11: begin f = 2'd2; o = w[22:15]; r1 = w[9:5]; r2 = w[14:10];
                         u = 3'b011; end
            default: begin f = 2'd0; o = 8'(w[23:21]); im = w[20:5]; r1 = w[4:0];
                           u = 3'b001; end
        endcase
        return {f, o, im, w[4:0], r1, r2, r3, u};
    endfunction

    function automatic logic [48:0] observed();
        return {bus.out_fmt, bus.out_op, bus.out_imm, bus.out_rd, bus.out_rs1,
                bus.out_rs2, bus.out_rs3, bus.out_use};
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (observed() !== 49'h0) begin n_bad++; $display("FAIL reset_fields got %h want 0", observed()); end
        n_cmp++; if (bus.instr_count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.instr_count); end
        @(negedge clk) rst_n = 1'b1;
        exp_count = '0;
    endtask

    task automatic test_decode();
        logic [24:0] w [3];
        logic [48:0] e [3];
        w[0] = 25'h04001E3; e[0] = {2'd0, 8'h02, 16'h000F, 5'd3, 5'd3, 5'd0, 5'd0, 3'b001};
        w[1] = 25'h15398A4; e[1] = {2'd1, 8'h05, 16'h0000, 5'd4, 5'd5, 5'd6, 5'd7, 3'b111};
        w[2] = 25'h185A501; e[2] = {2'd2, 8'h0B, 16'h0000, 5'd1, 5'd8, 5'd9, 5'd0, 3'b011};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = w[i];
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL decode%0d_no_bypass got %b want 0", i, bus.out_valid); end
            @(negedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL decode%0d_valid got %b want 1", i, bus.out_valid); end
            n_cmp++; if (observed() !== e[i]) begin n_bad++; $display("FAIL decode%0d_fields got %h want %h", i, observed(), e[i]); end
            n_cmp++; if (bus.instr_count !== exp_count) begin n_bad++; $display("FAIL decode%0d_count_before got %0d want %0d", i, bus.instr_count, exp_count); end
            exp_count++;
            @(negedge clk); #1;
            n_cmp++; if (bus.instr_count !== exp_count) begin n_bad++; $display("FAIL decode%0d_count_after got %0d want %0d", i, bus.instr_count, exp_count); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL decode%0d_drain got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_stall();
        logic [24:0] w [4];
        logic [48:0] hold;
        logic [48:0] exp;
        bit have_hold;
        int sent;
        int c;
        for (int i = 0; i < 4; i++) w[i] = 25'($urandom());
        sent = 0; have_hold = 0; hold = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = (sent < 4);
            if (sent < 4) bus.in_instr = w[sent];
            #1;
            if (bus.out_valid) begin
                if (have_hold) begin
                    n_cmp++; if (observed() !== hold) begin n_bad++; $display("FAIL stall_stable got %h want %h", observed(), hold); end
                end else begin
                    hold = observed(); have_hold = 1;
                    n_cmp++; if (hold !== exp_q[0]) begin n_bad++; $display("FAIL stall_first got %h want %h", hold, exp_q[0]); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin exp_q.push_back(model(bus.in_instr)); sent++; end
        end
        n_cmp++; if (sent !== DEPTH + 1) begin n_bad++; $display("FAIL stall_accepted got %0d want %0d", sent, DEPTH + 1); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready); end
        c = 0;
        while ((sent < 4 || exp_q.size() > 0) && c < 40) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid = (sent < 4);
            if (sent < 4) bus.in_instr = w[sent];
            #1;
            if (bus.out_valid && bus.out_ready) begin
                exp = exp_q.pop_front();
                exp_count++;
                n_cmp++; if (observed() !== exp) begin n_bad++; $display("FAIL stall_drain got %h want %h", observed(), exp); end
            end
            if (bus.in_valid && bus.in_ready) begin exp_q.push_back(model(bus.in_instr)); sent++; end
            c++;
        end
        n_cmp++; if (c >= 40) begin n_bad++; $display("FAIL stall_timeout got %0d left want 0", exp_q.size()); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.instr_count !== exp_count) begin n_bad++; $display("FAIL stall_count got %0d want %0d", bus.instr_count, exp_count); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 25'h0A5A5A5;
        @(negedge clk);
        bus.in_instr = 25'h1234567;
        @(negedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_setup got %b want 1", bus.out_valid); end
        bus.flush = 1'b1; bus.in_instr = 25'h1ABCDEF;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.instr_count !== exp_count) begin n_bad++; $display("FAIL flush_count got %0d want %0d", bus.instr_count, exp_count); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_ghost cycle %0d got %b want 0", k, bus.out_valid); end
        end
    endtask

    task automatic test_async_reset_stream();
        logic [48:0] exp;
        logic [48:0] prev;
        bit prev_stall;
        int sent, got, c, first_acc, first_val;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 25'h0F0F0F0;
        @(negedge clk);
        bus.in_instr = 25'h1F0F0F0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (observed() !== 49'h0) begin n_bad++; $display("FAIL areset_fields got %h want 0", observed()); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.instr_count !== '0) begin n_bad++; $display("FAIL areset_count got %0d want 0", bus.instr_count); end
        @(negedge clk) rst_n = 1'b1;
        exp_q.delete();
        exp_count = '0;
        sent = 0; got = 0; c = 0; first_acc = -1; first_val = -1; prev_stall = 0; prev = '0;
        while ((sent < 1000 || exp_q.size() > 0) && c < 20000) begin
            @(negedge clk);
            bus.in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.in_instr = 25'($urandom());
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (prev_stall) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || observed() !== prev) begin n_bad++; $display("FAIL stream_hold got %b/%h want 1/%h", bus.out_valid, observed(), prev); end
            end
            if (bus.out_valid && first_val < 0) first_val = c;
            if (bus.out_valid && bus.out_ready) begin
                exp = exp_q.pop_front();
                exp_count++; got++;
                n_cmp++; if (observed() !== exp) begin n_bad++; $display("FAIL stream_word%0d got %h want %h", got, observed(), exp); end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev = observed();
            if (bus.in_valid && bus.in_ready) begin
                if (first_acc < 0) first_acc = c;
                exp_q.push_back(model(bus.in_instr));
                sent++;
            end
            c++;
        end
        n_cmp++; if (c >= 20000) begin n_bad++; $display("FAIL stream_timeout got %0d delivered want 1000", got); end
        n_cmp++; if (first_val !== first_acc + 2) begin n_bad++; $display("FAIL stream_latency got cycle %0d want %0d", first_val, first_acc + 2); end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus.instr_count !== 16'd1000) begin n_bad++; $display("FAIL stream_count got %0d want 1000", bus.instr_count); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall();
        test_flush();
        test_async_reset_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
